rom_load_ctrl: RTL and testbench

ROM download sequencer sitting between `hps_io` and the `pacman` core in `emu`. It forwards the HPS ioctl byte stream to the core's `dn_*` ROM write port, decodes the target ROM region, counts the accepted bytes, and validates the image length. It also owns the core reset: the core is held in reset until a valid image has loaded, plus a fixed hold time, and on every user reset.

---
 rtl/rom_load_pkg.sv | 19 +
 rtl/rom_load_ctrl_rst_hold_timer.sv | 32 +++
 rtl/rom_load_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rom_load_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared FSM state type, dn_sel region codes and count width
// for the ROM download sequencer.
package rom_load_pkg;

  localparam int CNT_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  localparam logic [1:0] SEL_PGM  = 2'd0;
  localparam logic [1:0] SEL_GFX  = 2'd1;
  localparam logic [1:0] SEL_PROM = 2'd2;

endpackage

// File: rtl/rom_load_ctrl_rst_hold_timer.sv
// rst_hold_timer: HOLD-state countdown. Reloads on entry and while user_reset
// is held; done is raised in the cycle the counter sits at zero.
module rst_hold_timer #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  input  logic user_reset_i,
  output logic done_o
);

  localparam int W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || (en_i && user_reset_i)) cnt_d = LOAD_VAL;
    else if (en_i && (cnt_q != '0))      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = en_i && !user_reset_i && (cnt_q == '0);

endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: forwards the HPS ioctl ROM stream to the core's dn_* port,
// validates the image and sequences core reset. Optional: ROM_CHECKSUM_EN.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [15:0]      GFX_BASE     = 16'h4000,
  parameter logic [15:0]      PROM_BASE    = 16'h6000,
  parameter logic [CNT_W-1:0] ROM_BYTES    = 17'h06320,
  parameter int               HOLD_CYCLES  = 16,
  parameter logic [15:0]      EXPECTED_SUM = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [1:0]  dn_sel,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err,
  output logic [15:0] checksum
);

  state_e           state_q, state_d;
  logic             dl_q, dl_d, blk_q, blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ok_q, ok_d, err_q, err_d;
  logic             core_reset_q, core_reset_d;
  logic [15:0]      dn_addr_q, dn_addr_d;
  logic [7:0]       dn_data_q, dn_data_d;
  logic             dn_wr_q, dn_wr_d;
  logic [1:0]       dn_sel_q, dn_sel_d;

  logic       rise, fall, in_range, wr_ld, accept, ld_start;
  logic       sum_ok, pass, hold_done;
  logic [1:0] region;

  // blk_q masks the rise seen right after a RESET that lands mid-download,
  // so the tail of that download is ignored until the line drops.
  assign rise     = ioctl_download && !dl_q && !blk_q;
  assign fall     = !ioctl_download && dl_q;
  assign in_range = (ioctl_addr[24:16] == 9'd0) && ({1'b0, ioctl_addr[15:0]} < ROM_BYTES);
  assign wr_ld    = ioctl_wr && (state_q == ST_LOAD);
  assign accept   = wr_ld && in_range;
  assign ld_start = (state_d == ST_LOAD) && (state_q != ST_LOAD);
  assign pass     = (cnt_q == ROM_BYTES) && !ovf_q && sum_ok;

  always_comb begin
    region = SEL_PGM;
    if (ioctl_addr[15:0] >= PROM_BASE)     region = SEL_PROM;
    else if (ioctl_addr[15:0] >= GFX_BASE) region = SEL_GFX;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rise) state_d = ST_LOAD;
      ST_LOAD:  if (fall) state_d = ST_CHECK;
      ST_CHECK: state_d = pass ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (rise)           state_d = ST_LOAD;
        else if (hold_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rise)            state_d = ST_LOAD;
        else if (user_reset) state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dl_d         = ioctl_download;
    blk_d        = blk_q && ioctl_download;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    ok_d         = ok_q;
    err_d        = err_q;
    dn_wr_d      = accept;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_sel_d     = dn_sel_q;
    core_reset_d = (state_d != ST_RUN);
    if (ld_start) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      ok_d  = 1'b0;
      err_d = 1'b0;
    end
    if (accept) begin
      dn_addr_d = ioctl_addr[15:0];
      dn_data_d = ioctl_dout;
      dn_sel_d  = region;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    if (wr_ld && !in_range) ovf_d = 1'b1;
    if (state_q == ST_CHECK) begin
      ok_d  = pass;
      err_d = !pass;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b0;
      blk_q        <= 1'b1;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_sel_q     <= SEL_PGM;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      blk_q        <= blk_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      core_reset_q <= core_reset_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_sel_q     <= dn_sel_d;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (ld_start)    sum_d = '0;
    else if (accept) sum_d = sum_q + {8'h00, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_ok   = (sum_q == EXPECTED_SUM);
  assign checksum = sum_q;
`else
  assign sum_ok   = 1'b1;
  assign checksum = '0;
`endif

  rst_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk          (clk_sys),
    .rst          (RESET),
    .load_i       ((state_d == ST_HOLD) && (state_q != ST_HOLD)),
    .en_i         (state_q == ST_HOLD),
    .user_reset_i (user_reset),
    .done_o       (hold_done)
  );

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign dn_sel     = dn_sel_q;
  assign core_reset = core_reset_q;
  assign load_ok    = ok_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: randomized ROM downloads checked against a byte-level
// model of acceptance, region, count, checksum and reset sequencing.
module tb_rom_load_ctrl;

  localparam int ROM_N  = 'h6320;
  localparam int HOLD_N = 16;
`ifdef ROM_CHECKSUM_EN
  localparam bit          CHK_EN  = 1'b1;
  localparam logic [15:0] EXP_SUM = 16'h1234;
`else
  localparam bit          CHK_EN  = 1'b0;
  localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

  logic        clk_sys = 1'b0;
  logic        RESET, ioctl_download, ioctl_wr, user_reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr, checksum;
  logic [7:0]  dn_data;
  logic        dn_wr, core_reset, load_ok, load_err;
  logic [1:0]  dn_sel;

  always #5 clk_sys = ~clk_sys;

  rom_load_ctrl #(
    .GFX_BASE(16'h4000), .PROM_BASE(16'h6000), .ROM_BYTES(17'h06320),
    .HOLD_CYCLES(HOLD_N), .EXPECTED_SUM(EXP_SUM)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .user_reset(user_reset), .dn_addr(dn_addr), .dn_data(dn_data),
    .dn_wr(dn_wr), .dn_sel(dn_sel), .core_reset(core_reset),
    .load_ok(load_ok), .load_err(load_err), .checksum(checksum)
  );

  int vec = 0, errs = 0;
  logic [7:0]  img [0:ROM_N-1];
  // model: what the downloader should have seen so far
  bit          m_loading, pend;
  logic [15:0] pend_addr, m_sum;
  logic [7:0]  pend_data;
  logic [1:0]  pend_sel, sel_3fff, sel_4000, sel_6000;
  int          n_acc, n_rej, stream_bad;

  function automatic logic [1:0] region(input int a);
    if (a >= 'h6000) return 2'd2;
    if (a >= 'h4000) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_pass();
    return (n_acc == ROM_N) && (n_rej == 0) && (!CHK_EN || m_sum == EXP_SUM);
  endfunction

  // One cycle: verify dn_* for last cycle's strobe, then drive the next one.
  task automatic step(input bit dl, input bit wr, input int a, input logic [7:0] d);
    @(negedge clk_sys);
    if (pend) begin
      if (dn_wr !== 1'b1 || dn_addr !== pend_addr || dn_data !== pend_data || dn_sel !== pend_sel)
        stream_bad++;
      if (pend_addr == 16'h3FFF) sel_3fff = dn_sel;
      if (pend_addr == 16'h4000) sel_4000 = dn_sel;
      if (pend_addr == 16'h6000) sel_6000 = dn_sel;
    end else if (dn_wr !== 1'b0) stream_bad++;
    ioctl_download = dl; ioctl_wr = wr; ioctl_addr = 25'(a); ioctl_dout = d;
    pend      = wr && m_loading && (a < ROM_N);
    pend_addr = 16'(a); pend_data = d; pend_sel = region(a);
    if (pend) begin n_acc++; m_sum = m_sum + 16'(d); end
    else if (wr && m_loading) n_rej++;
  endtask

  task automatic make_image(input bit fix, input logic [15:0] target);
    logic [15:0] s;
    int diff, add;
    s = 16'h0;
    for (int i = 0; i < ROM_N; i++) begin
      img[i] = 8'($urandom);
      s = s + 16'(img[i]);
    end
    if (fix) begin
      diff = int'(16'(target - s));
      for (int i = 0; i < ROM_N && diff > 0; i++) begin
        add = 255 - int'(img[i]);
        if (add > diff) add = diff;
        img[i] = img[i] + 8'(add);
        diff -= add;
      end
    end
  endtask

  // Rise, n sequential bytes, fall; returns at the second cycle after the
  // fall is sampled, where load_ok/load_err first become visible.
  task automatic do_load(input int n, input bit fall_with_last, input bit inject_oor);
    step(1, 0, 0, 8'h00);
    m_loading = 1; n_acc = 0; n_rej = 0; m_sum = 16'h0;
    for (int i = 0; i < n; i++) begin
      if (inject_oor && i == 100) begin
        step(1, 1, 'h10000, 8'hA5);
        step(1, 1, ROM_N, 8'h5A);
      end
      step((fall_with_last && i == n - 1) ? 1'b0 : 1'b1, 1, i, img[i]);
    end
    if (!fall_with_last) step(0, 0, 0, 8'h00);
    m_loading = 0;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(negedge clk_sys);
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL reset.core_reset got %b want 1", core_reset); end
    vec++; if (dn_wr !== 1'b0) begin errs++; $display("FAIL reset.dn_wr got %b want 0", dn_wr); end
    vec++; if (dn_addr !== 16'h0 || dn_data !== 8'h0 || dn_sel !== 2'd0) begin errs++; $display("FAIL reset.dn_bus got %h/%h/%0d want 0/0/0", dn_addr, dn_data, dn_sel); end
    vec++; if (load_ok !== 1'b0 || load_err !== 1'b0) begin errs++; $display("FAIL reset.status got ok=%b err=%b want 0/0", load_ok, load_err); end
    vec++; if (checksum !== 16'h0) begin errs++; $display("FAIL reset.checksum got %h want 0000", checksum); end
    RESET = 0;
  endtask

  task automatic test_reset_mid_download();
    stream_bad = 0;
    step(1, 0, 0, 8'h00);
    m_loading = 1; n_acc = 0; n_rej = 0; m_sum = 16'h0;
    for (int i = 0; i < 4; i++) step(1, 1, i, 8'($urandom));
    step(1, 0, 0, 8'h00);
    RESET = 1; m_loading = 0;
    step(1, 0, 0, 8'h00);
    RESET = 0;
    for (int i = 4; i < 12; i++) step(1, 1, i, 8'($urandom));
    step(0, 0, 0, 8'h00);
    repeat (3) step(0, 0, 0, 8'h00);
    vec++; if (stream_bad !== 0) begin errs++; $display("FAIL rst_mid.dn_stream got %0d bad cycles want 0", stream_bad); end
    vec++; if (load_ok !== 1'b0 || load_err !== 1'b0) begin errs++; $display("FAIL rst_mid.status got ok=%b err=%b want 0/0", load_ok, load_err); end
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL rst_mid.core_reset got %b want 1", core_reset); end
  endtask

  task automatic test_short_load();
    int bad_cr;
    stream_bad = 0; bad_cr = 0;
    make_image(1'b0, 16'h0);
    do_load('h6000, 0, 0);
    vec++; if (stream_bad !== 0) begin errs++; $display("FAIL short.dn_stream got %0d bad cycles want 0", stream_bad); end
    vec++; if (load_err !== !m_pass() || load_ok !== m_pass()) begin errs++; $display("FAIL short.status got ok=%b err=%b want %b/%b", load_ok, load_err, m_pass(), !m_pass()); end
    for (int k = 0; k < 60; k++) begin
      step(0, 0, 0, 8'h00);
      if (core_reset !== 1'b1) bad_cr++;
    end
    vec++; if (bad_cr !== 0) begin errs++; $display("FAIL short.core_reset_held got %0d low cycles want 0", bad_cr); end
    // FSM is idle: a strobe with the download line low must not reach the core
    step(0, 1, 5, 8'h33);
    step(0, 0, 0, 8'h00);
    vec++; if (stream_bad !== 0) begin errs++; $display("FAIL short.idle_wr got %0d bad cycles want 0", stream_bad); end
  endtask

  task automatic test_out_of_range();
    stream_bad = 0;
    make_image(1'b0, 16'h0);
    do_load(ROM_N, 0, 1);
    vec++; if (stream_bad !== 0) begin errs++; $display("FAIL oor.dn_stream got %0d bad cycles want 0", stream_bad); end
    vec++; if (load_err !== !m_pass() || load_ok !== m_pass()) begin errs++; $display("FAIL oor.status got ok=%b err=%b want %b/%b", load_ok, load_err, m_pass(), !m_pass()); end
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL oor.core_reset got %b want 1", core_reset); end
  endtask

  task automatic test_checksum();
    stream_bad = 0;
    make_image(1'b1, 16'h1233);
    do_load(ROM_N, 0, 0);
    vec++; if (checksum !== m_sum) begin errs++; $display("FAIL csum.checksum got %h want %h", checksum, m_sum); end
    vec++; if (load_err !== !m_pass() || load_ok !== m_pass()) begin errs++; $display("FAIL csum.status got ok=%b err=%b want %b/%b", load_ok, load_err, m_pass(), !m_pass()); end
  endtask

  // Last strobe coincides with the download fall; the load must still pass.
  task automatic test_full_load();
    stream_bad = 0; sel_3fff = 2'bxx; sel_4000 = 2'bxx; sel_6000 = 2'bxx;
    make_image(CHK_EN, EXP_SUM);
    do_load(ROM_N, 1, 0);
    vec++; if (stream_bad !== 0) begin errs++; $display("FAIL full.dn_stream got %0d bad cycles want 0", stream_bad); end
    vec++; if (sel_3fff !== 2'd0) begin errs++; $display("FAIL full.sel_3fff got %0d want 0", sel_3fff); end
    vec++; if (sel_4000 !== 2'd1) begin errs++; $display("FAIL full.sel_4000 got %0d want 1", sel_4000); end
    vec++; if (sel_6000 !== 2'd2) begin errs++; $display("FAIL full.sel_6000 got %0d want 2", sel_6000); end
    vec++; if (load_ok !== m_pass() || load_err !== !m_pass()) begin errs++; $display("FAIL full.status got ok=%b err=%b want %b/%b", load_ok, load_err, m_pass(), !m_pass()); end
    vec++; if (checksum !== (CHK_EN ? m_sum : 16'h0)) begin errs++; $display("FAIL full.checksum got %h want %h", checksum, CHK_EN ? m_sum : 16'h0); end
    // HOLD was entered at the edge just before this sample point
    repeat (HOLD_N) step(0, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL full.core_reset_hold got %b want 1", core_reset); end
    step(0, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b0) begin errs++; $display("FAIL full.core_reset_release got %b want 0", core_reset); end
  endtask

  task automatic test_user_reset();
    step(0, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b0) begin errs++; $display("FAIL ures.run got %b want 0", core_reset); end
    user_reset = 1;
    step(0, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL ures.rise got %b want 1", core_reset); end
    repeat (4) step(0, 0, 0, 8'h00);
    user_reset = 0;
    // release is first sampled one edge later; core_reset drops 16 edges after that
    repeat (HOLD_N) step(0, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL ures.hold got %b want 1", core_reset); end
    step(0, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b0) begin errs++; $display("FAIL ures.release got %b want 0", core_reset); end
  endtask

  task automatic test_reload_from_run();
    int n;
    n = $urandom_range(1, 40);
    stream_bad = 0;
    step(1, 0, 0, 8'h00);
    m_loading = 1; n_acc = 0; n_rej = 0; m_sum = 16'h0;
    step(1, 0, 0, 8'h00);
    vec++; if (core_reset !== 1'b1) begin errs++; $display("FAIL reload.core_reset got %b want 1", core_reset); end
    vec++; if (load_ok !== 1'b0 || load_err !== 1'b0) begin errs++; $display("FAIL reload.cleared got ok=%b err=%b want 0/0", load_ok, load_err); end
    for (int i = 0; i < n; i++) step(1, 1, $urandom_range(0, ROM_N - 1), 8'($urandom));
    step(0, 0, 0, 8'h00);
    m_loading = 0;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    vec++; if (stream_bad !== 0) begin errs++; $display("FAIL reload.dn_stream got %0d bad cycles want 0", stream_bad); end
    vec++; if (load_err !== !m_pass() || load_ok !== m_pass()) begin errs++; $display("FAIL reload.status got ok=%b err=%b want %b/%b", load_ok, load_err, m_pass(), !m_pass()); end
  endtask

  initial begin
    RESET = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0;
    user_reset = 0; m_loading = 0; pend = 0; m_sum = 16'h0;
    n_acc = 0; n_rej = 0; stream_bad = 0;
    test_reset();
    test_reset_mid_download();
    test_short_load();
`ifdef ROM_CHECKSUM_EN
    test_checksum();
`else
    test_out_of_range();
`endif
    test_full_load();
    test_user_reset();
    test_reload_from_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
